// File: rtl/seg_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared FSM encoding, inactive levels and hex segment table for the
//           multiplexed seven-segment scan driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    typedef logic [0:0] scanState_t;

    localparam scanState_t c_ST_IDLE = 1'b0;
    localparam scanState_t c_ST_SHOW = 1'b1;

    localparam logic c_OFF_ACTIVE_LOW  = 1'b1;
    localparam logic c_OFF_ACTIVE_HIGH = 1'b0;

    // Active-high patterns, segment a at bit 0; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] c_HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ============================================================================
// Module  : hex_to_seg
// Brief   : Combinational nibble to active-high seven-segment pattern decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segs
);

    assign o_segs = c_HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module  : seg_scan_driver
// Brief   : Tear-free multiplexed seven-segment scan driver with leading-zero
//           blanking and per-digit decimal points.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clockIn,
    input  logic                    resetN,
    input  logic                    scanTick,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dpIn,
    output logic [6:0]              segOut,
    output logic                    dpOut,
    output logic [NUM_DIGITS-1:0]   anodeOut,
    output logic                    frameDone
);

    localparam int                    c_IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic                  c_OFF       = (ACTIVE_LOW != 0) ? c_OFF_ACTIVE_LOW
                                                                      : c_OFF_ACTIVE_HIGH;
    localparam logic [6:0]            c_SEG_OFF   = {7{c_OFF}};
    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF = {NUM_DIGITS{c_OFF}};

    scanState_t                  r_state;
    logic [c_IDX_W-1:0]          r_index;
    logic [4*NUM_DIGITS-1:0]     r_shadowVal;
    logic [NUM_DIGITS-1:0]       r_shadowDp;
    logic [6:0]                  r_seg;
    logic                        r_dp;
    logic [NUM_DIGITS-1:0]       r_anode;
    logic                        r_frame;

    scanState_t                  w_stateNext;
    logic [c_IDX_W-1:0]          w_indexNext;
    logic                        w_loadShadow;
    logic                        w_frameNext;
    logic [4*NUM_DIGITS-1:0]     w_dispVal;
    logic [NUM_DIGITS-1:0]       w_dispDp;
    logic [NUM_DIGITS-1:0]       w_zeroAbove;
    logic [NUM_DIGITS-1:0]       w_oneHot;
    logic [3:0]                  w_nibble;
    logic                        w_digitDp;
    logic                        w_blank;
    logic                        w_allZero;
    logic [6:0]                  w_segRaw;
    logic [6:0]                  w_segNext;
    logic                        w_dpNext;
    logic [NUM_DIGITS-1:0]       w_anodeNext;

    // State, index, shadow and output registers all advance on the same edge.
    always_ff @(posedge clockIn) begin
        if (!resetN) begin
            r_state     <= c_ST_IDLE;
            r_index     <= '0;
            r_shadowVal <= '0;
            r_shadowDp  <= '0;
            r_seg       <= c_SEG_OFF;
            r_dp        <= c_OFF;
            r_anode     <= c_ANODE_OFF;
            r_frame     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_index <= w_indexNext;
            if (w_loadShadow) begin
                r_shadowVal <= value;
                r_shadowDp  <= dpIn;
            end
            r_seg   <= w_segNext;
            r_dp    <= w_dpNext;
            r_anode <= w_anodeNext;
            r_frame <= w_frameNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_indexNext  = r_index;
        w_loadShadow = 1'b0;
        w_frameNext  = 1'b0;
        if (!enable) begin
            w_stateNext = c_ST_IDLE;
            w_indexNext = '0;
        end else if (scanTick) begin
            if (r_state == c_ST_IDLE) begin
                w_stateNext  = c_ST_SHOW;
                w_indexNext  = '0;
                w_loadShadow = 1'b1;
            end else if (r_index == c_LAST_IDX) begin
                w_indexNext  = '0;
                w_loadShadow = 1'b1;
                w_frameNext  = 1'b1;
            end else begin
                w_indexNext = r_index + c_IDX_W'(1);
            end
        end
    end

    // On a frame start the fresh input bypasses the shadow so digit 0 is current.
    assign w_dispVal = w_loadShadow ? value : r_shadowVal;
    assign w_dispDp  = w_loadShadow ? dpIn  : r_shadowDp;

    always_comb begin
        w_nibble    = '0;
        w_digitDp   = 1'b0;
        w_oneHot    = '0;
        w_zeroAbove = '0;
        w_blank     = 1'b0;
        w_allZero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_allZero      = w_allZero & (w_dispVal[i*4 +: 4] == 4'h0);
            w_zeroAbove[i] = w_allZero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_indexNext == c_IDX_W'(i)) begin
                w_nibble    = w_dispVal[i*4 +: 4];
                w_digitDp   = w_dispDp[i];
                w_oneHot[i] = 1'b1;
                w_blank     = (BLANK_LZ != 0) && (i != 0) && w_zeroAbove[i];
            end
        end
    end

    hex_to_seg u_hexToSeg (
        .i_nibble (w_nibble),
        .o_segs   (w_segRaw)
    );

    // XOR with the inactive level maps active-high data onto either polarity.
    always_comb begin
        w_segNext   = c_SEG_OFF;
        w_dpNext    = c_OFF;
        w_anodeNext = c_ANODE_OFF;
        if (w_stateNext == c_ST_SHOW) begin
            w_anodeNext = c_ANODE_OFF ^ w_oneHot;
            w_segNext   = w_blank ? c_SEG_OFF : (w_segRaw ^ c_SEG_OFF);
            w_dpNext    = w_digitDp ^ c_OFF;
        end
    end

    assign segOut    = r_seg;
    assign dpOut     = r_dp;
    assign anodeOut  = r_anode;
    assign frameDone = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module  : tb_seg_scan_driver
// Brief   : Directed table-driven bench for seg_scan_driver (4 digits,
//           active-low, leading-zero blanking, tick every 4 cycles).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    logic        clockIn = 1'b0;
    logic        resetN;
    logic        scanTick;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dpIn;
    logic [6:0]  segOut;
    logic        dpOut;
    logic [3:0]  anodeOut;
    logic        frameDone;

    int errors = 0;
    int checks = 0;

    always #5 clockIn = ~clockIn;

    seg_scan_driver #(
        .NUM_DIGITS (4),
        .BLANK_LZ   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clockIn   (clockIn),
        .resetN    (resetN),
        .scanTick  (scanTick),
        .enable    (enable),
        .value     (value),
        .dpIn      (dpIn),
        .segOut    (segOut),
        .dpOut     (dpOut),
        .anodeOut  (anodeOut),
        .frameDone (frameDone)
    );

    typedef struct {
        string       name;
        logic        rstN;
        logic        en;
        logic        tick;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  expAnode;
        logic [6:0]  expSeg;
        logic        expDp;
        logic        expFrame;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rstN, input logic en, input logic tick,
                       input logic [15:0] val, input logic [3:0] dp, input logic [3:0] expAnode,
                       input logic [6:0] expSeg, input logic expDp, input logic expFrame);
        vec_t v;
        v.name = name; v.rstN = rstN; v.en = en; v.tick = tick; v.val = val; v.dp = dp;
        v.expAnode = expAnode; v.expSeg = expSeg; v.expDp = expDp; v.expFrame = expFrame;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   highs;
        int   rises;
        int   foundAt;
        logic prevFrame;

        resetN = 1'b0; enable = 1'b0; scanTick = 1'b0; value = '0; dpIn = '0;

        // name           rstN en tick value    dp    anode  seg    dp frame
        add("reset",       0, 1, 1, 16'h1234, 4'h0, 4'hF, 7'h7F, 1, 0);
        add("scan d0",     1, 1, 1, 16'h1234, 4'h0, 4'hE, 7'h19, 1, 0);
        add("scan d1",     1, 1, 1, 16'h1234, 4'h0, 4'hD, 7'h30, 1, 0);
        add("scan d2",     1, 1, 1, 16'h1234, 4'h0, 4'hB, 7'h24, 1, 0);
        add("scan d3",     1, 1, 1, 16'h1234, 4'h0, 4'h7, 7'h79, 1, 0);
        add("wrap1",       1, 1, 1, 16'h1234, 4'h0, 4'hE, 7'h19, 1, 1);
        add("f2 d1",       1, 1, 1, 16'h1234, 4'h0, 4'hD, 7'h30, 1, 0);
        add("f2 d2",       1, 1, 1, 16'h1234, 4'h0, 4'hB, 7'h24, 1, 0);
        add("tear d2",     1, 1, 0, 16'hABCD, 4'h0, 4'hB, 7'h24, 1, 0);
        add("tear d3",     1, 1, 1, 16'hABCD, 4'h0, 4'h7, 7'h79, 1, 0);
        add("tear wrap",   1, 1, 1, 16'hABCD, 4'h0, 4'hE, 7'h21, 1, 1);
        add("f3 d1",       1, 1, 1, 16'hABCD, 4'h0, 4'hD, 7'h46, 1, 0);
        add("f3 d2",       1, 1, 1, 16'h0050, 4'h8, 4'hB, 7'h03, 1, 0);
        add("f3 d3",       1, 1, 1, 16'h0050, 4'h8, 4'h7, 7'h08, 1, 0);
        add("blank d0",    1, 1, 1, 16'h0050, 4'h8, 4'hE, 7'h40, 1, 1);
        add("blank d1",    1, 1, 1, 16'h0050, 4'h8, 4'hD, 7'h12, 1, 0);
        add("blank d2",    1, 1, 1, 16'h0050, 4'h8, 4'hB, 7'h7F, 1, 0);
        add("blank d3",    1, 1, 1, 16'h0050, 4'h8, 4'h7, 7'h7F, 0, 0);
        add("f5 d0",       1, 1, 1, 16'h1234, 4'h0, 4'hE, 7'h19, 1, 1);
        add("f5 d1",       1, 1, 1, 16'h1234, 4'h0, 4'hD, 7'h30, 1, 0);
        add("f5 d2",       1, 1, 1, 16'h1234, 4'h0, 4'hB, 7'h24, 1, 0);
        add("en drop",     1, 0, 1, 16'h1234, 4'h0, 4'hF, 7'h7F, 1, 0);
        add("re-enable",   1, 1, 1, 16'h5678, 4'h0, 4'hE, 7'h00, 1, 0);
        add("re d1",       1, 1, 1, 16'h5678, 4'h0, 4'hD, 7'h78, 1, 0);
        add("mid reset",   0, 1, 0, 16'h5678, 4'h0, 4'hF, 7'h7F, 1, 0);
        add("restart d0",  1, 1, 1, 16'h0009, 4'h0, 4'hE, 7'h10, 1, 0);
        add("restart d1",  1, 1, 1, 16'h0009, 4'h0, 4'hD, 7'h7F, 1, 0);
        add("restart d2",  1, 1, 1, 16'h0009, 4'h0, 4'hB, 7'h7F, 1, 0);
        add("restart d3",  1, 1, 1, 16'h0009, 4'h0, 4'h7, 7'h7F, 1, 0);
        add("restart wrap",1, 1, 1, 16'h0009, 4'h0, 4'hE, 7'h10, 1, 1);

        foreach (vecs[k]) begin
            v = vecs[k];
            @(negedge clockIn);
            resetN = v.rstN; enable = v.en; scanTick = v.tick; value = v.val; dpIn = v.dp;
            @(posedge clockIn); #1;
            check({v.name, " anode"}, 32'(anodeOut), 32'(v.expAnode));
            check({v.name, " seg"},   32'(segOut),   32'(v.expSeg));
            check({v.name, " dp"},    32'(dpOut),    32'(v.expDp));
            check({v.name, " frame"}, 32'(frameDone), 32'(v.expFrame));
            if (v.tick) begin
                for (int p = 0; p < 3; p++) begin
                    @(negedge clockIn);
                    scanTick = 1'b0;
                    @(posedge clockIn); #1;
                    check({v.name, " hold anode"}, 32'(anodeOut), 32'(v.expAnode));
                    check({v.name, " hold seg"},   32'(segOut),   32'(v.expSeg));
                    check({v.name, " hold frame"}, 32'(frameDone), 32'h0);
                end
            end
        end

        // Free-running ticks over two frames: exactly two single-cycle pulses.
        highs = 0; rises = 0; prevFrame = frameDone;
        for (int c = 0; c < 32; c++) begin
            @(negedge clockIn);
            scanTick = (c % 4 == 0);
            @(posedge clockIn); #1;
            if (frameDone) highs++;
            if (frameDone && !prevFrame) rises++;
            prevFrame = frameDone;
        end
        check("pulse high cycles", 32'(highs), 32'd2);
        check("pulse count",       32'(rises), 32'd2);

        // Bounded wait for the next frame start; 4 ticks after digit 0.
        foundAt = -1;
        for (int c = 0; c < 20 && foundAt < 0; c++) begin
            @(negedge clockIn);
            scanTick = (c % 4 == 0);
            @(posedge clockIn); #1;
            if (frameDone) foundAt = c;
        end
        check("frame wait cycle", 32'(foundAt), 32'd12);
        check("frame wait d0 seg", 32'(segOut), 32'h10);

        @(negedge clockIn);
        scanTick = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
